// File: rtl/tacos_alu_sequencer_if.sv
// tacos_alu_sequencer_if: command, unit-control and status signals between the register block and the sequencer
interface tacos_alu_sequencer_if;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic       cmd_ready;
  logic       cmd_abort;
  logic       mul_start;
  logic       mul_b_sel;
  logic       mul_done;
  logic       mul_ovf;
  logic       sqrt_start;
  logic       sqrt_src_sel;
  logic       sqrt_valid;
  logic       c_we;
  logic [2:0] c_src;
  logic       busy;
  logic       done;
  logic       err_ovf;
  logic       err_timeout;
  logic       irq_en;
  logic       irq_clr;
  logic       irq;
  modport master (
    output cmd_valid, cmd_op, cmd_abort, mul_done, mul_ovf, sqrt_valid, irq_en, irq_clr,
    input  cmd_ready, mul_start, mul_b_sel, sqrt_start, sqrt_src_sel, c_we, c_src, busy, done,
           err_ovf, err_timeout, irq
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_abort, mul_done, mul_ovf, sqrt_valid, irq_en, irq_clr,
    output cmd_ready, mul_start, mul_b_sel, sqrt_start, sqrt_src_sel, c_we, c_src, busy, done,
           err_ovf, err_timeout, irq
  );
endinterface

// File: rtl/tacos_alu_sequencer.sv
// tacos_alu_sequencer: chains mul/sqrt unit invocations per opcode with abort, timeout and irq reporting
module tacos_alu_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic                  clk,
  input logic                  rst,
  tacos_alu_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL1, MUL1_W, MUL2, MUL2_W, SQ, SQ_W, WB} state_t;
  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          term_q, term_d, ovf_q, ovf_d, tmo_q, tmo_d, irq_q, irq_d;
  logic          accept, wait_st, comp, abort, tmo, chain, done;
  logic [2:0]    wb_src;
  assign accept  = bus.cmd_valid & (state_q == IDLE);
  assign wait_st = state_q inside {MUL1_W, MUL2_W, SQ_W};
  assign comp    = (state_q == SQ_W) ? bus.sqrt_valid : bus.mul_done;
  assign abort   = bus.cmd_abort & (state_q != IDLE);
  assign tmo     = wait_st & ~comp & (cnt_q == TW'(TIMEOUT));
  assign chain   = op_q[2:1] == 2'b11;
  // ops 2/3 write mul results, everything else below 8 picks quotient/remainder by bit 0
  assign wb_src  = op_q[3] ? 3'd4 : (op_q[2:1] == 2'b01) ? {1'b0, op_q[1:0]} : {2'b00, op_q[0]};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : bus.cmd_op[3] ? WB : bus.cmd_op[1] ? MUL1 : SQ;
      MUL1:    state_d = MUL1_W;
      MUL1_W:  state_d = !comp ? MUL1_W : chain ? MUL2 : WB;
      MUL2:    state_d = MUL2_W;
      MUL2_W:  state_d = comp ? SQ : MUL2_W;
      SQ:      state_d = SQ_W;
      SQ_W:    state_d = comp ? WB : SQ_W;
      default: state_d = IDLE;
    endcase
    if (abort || tmo) state_d = IDLE;
  end
  assign op_d   = accept ? bus.cmd_op : op_q;
  assign cnt_d  = wait_st ? cnt_q + TW'(1) : '0;
  assign term_d = (abort & (state_q != WB)) | tmo;
  assign ovf_d  = ~accept & (ovf_q | (wait_st & (state_q != SQ_W) & bus.mul_done & bus.mul_ovf & ~abort));
  assign tmo_d  = ~accept & (tmo_q | (tmo & ~abort));
  assign irq_d  = (done & bus.irq_en) | (irq_q & ~bus.irq_clr);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      term_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      irq_q   <= irq_d;
    end
  end
  // abort/timeout end the op from IDLE with a registered done pulse
  assign done             = (state_q == WB) | term_q;
  assign bus.done         = done;
  assign bus.cmd_ready    = state_q == IDLE;
  assign bus.busy         = state_q != IDLE;
  assign bus.mul_start    = state_q inside {MUL1, MUL2};
  assign bus.mul_b_sel    = state_q inside {MUL2, MUL2_W};
  assign bus.sqrt_start   = state_q == SQ;
  assign bus.sqrt_src_sel = (state_q inside {SQ, SQ_W}) & op_q[2];
  assign bus.c_we         = (state_q == MUL2) | ((state_q == SQ) & chain) | ((state_q == WB) & ~bus.cmd_abort);
  assign bus.c_src        = (state_q == MUL2) ? 3'd2 : ((state_q == SQ) & chain) ? 3'd3 : (state_q == WB) ? wb_src : 3'd0;
  assign bus.err_ovf      = ovf_q;
  assign bus.err_timeout  = tmo_q;
  assign bus.irq          = irq_q;
endmodule

// File: tb/tb_tacos_alu_sequencer.sv
// tb_tacos_alu_sequencer: directed op sequences against a latency-configurable mul/sqrt responder
module tb_tacos_alu_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errs = 0;
  int   mul_lat = 0;
  int   sq_lat = 0;
  logic ovf_cfg = 1'b0;
  int   mc, sc;
  int   we_n, done_n, done_cyc, rdy_cyc, st_cyc, ms_n, ss_n, both, ovf1;
  int   src [4];
  int   wc [4];
  logic bsel, ssel;
  tacos_alu_sequencer_if bus ();
  tacos_alu_sequencer #(.TIMEOUT(4), .TW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // unit model: completion pulse lat cycles after the start pulse, lat 0 never completes
  initial begin
    mc = 0;
    sc = 0;
    bus.mul_done = 1'b0;
    bus.mul_ovf = 1'b0;
    bus.sqrt_valid = 1'b0;
    forever begin
      @(negedge clk);
      mc = rst ? 0 : bus.mul_start ? 1 : (mc != 0) ? mc + 1 : 0;
      sc = rst ? 0 : bus.sqrt_start ? 1 : (sc != 0) ? sc + 1 : 0;
      bus.mul_done = (mul_lat != 0) && (mc == mul_lat + 1);
      bus.mul_ovf = bus.mul_done & ovf_cfg;
      bus.sqrt_valid = (sq_lat != 0) && (sc == sq_lat + 1);
      if (bus.mul_done) mc = 0;
      if (bus.sqrt_valid) sc = 0;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input int n, input int abort_at, input int clr_at);
    we_n = 0; done_n = 0; done_cyc = -1; rdy_cyc = -1; st_cyc = -1;
    ms_n = 0; ss_n = 0; both = 0; ovf1 = -1; bsel = 1'b0; ssel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src[i] = -1;
      wc[i] = -1;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    for (int c = 1; c <= n; c++) begin
      tick;
      bus.cmd_valid = 1'b0;
      bus.cmd_abort = (c == abort_at);
      bus.irq_clr = (c == clr_at);
      #1;
      if (c == 1) ovf1 = int'(bus.err_ovf);
      if (bus.c_we) begin
        if (we_n < 4) begin
          src[we_n] = int'(bus.c_src);
          wc[we_n] = c;
        end
        we_n++;
      end
      if (bus.done) begin
        done_n++;
        done_cyc = c;
      end
      if ((bus.mul_start || bus.sqrt_start) && st_cyc < 0) st_cyc = c;
      if (bus.mul_start) begin
        ms_n++;
        bsel = bus.mul_b_sel;
      end
      if (bus.sqrt_start) begin
        ss_n++;
        ssel = bus.sqrt_src_sel;
      end
      if (bus.cmd_ready && rdy_cyc < 0) rdy_cyc = c;
      if (bus.cmd_ready && bus.busy) both++;
    end
    bus.cmd_abort = 1'b0;
    bus.irq_clr = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 4'd0;
    bus.cmd_abort = 1'b0;
    bus.irq_en = 1'b0;
    bus.irq_clr = 1'b0;
    tick;
    tick;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_we", bus.c_we, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_errs", {bus.err_ovf, bus.err_timeout}, 0);
    rst = 1'b0;
    tick;
    mul_lat = 5;
    run(4'd2, 9, 0, 0);
    chk("op2_start_cyc", st_cyc, 1);
    chk("op2_we_n", we_n, 1);
    chk("op2_we_cyc", wc[0], 7);
    chk("op2_src", src[0], 2);
    chk("op2_done_n", done_n, 1);
    chk("op2_done_cyc", done_cyc, 7);
    chk("op2_ready_cyc", rdy_cyc, 8);
    chk("op2_bsel", bsel, 0);
    chk("op2_ready_busy", both, 0);
    mul_lat = 3;
    sq_lat = 3;
    run(4'd6, 15, 0, 0);
    chk("op6_we_n", we_n, 3);
    chk("op6_src0", src[0], 2);
    chk("op6_cyc0", wc[0], 5);
    chk("op6_src1", src[1], 3);
    chk("op6_cyc1", wc[1], 9);
    chk("op6_src2", src[2], 0);
    chk("op6_cyc2", wc[2], 13);
    chk("op6_done_n", done_n, 1);
    chk("op6_done_cyc", done_cyc, 13);
    chk("op6_mul_starts", ms_n, 2);
    chk("op6_mul2_bsel", bsel, 1);
    chk("op6_sqrt_starts", ss_n, 1);
    chk("op6_ssel", ssel, 1);
    chk("op6_ready_cyc", rdy_cyc, 14);
    mul_lat = 2;
    ovf_cfg = 1'b1;
    run(4'd3, 6, 0, 0);
    chk("op3_we_n", we_n, 1);
    chk("op3_src", src[0], 3);
    chk("op3_we_cyc", wc[0], 4);
    chk("op3_done_cyc", done_cyc, 4);
    chk("op3_err_ovf", bus.err_ovf, 1);
    ovf_cfg = 1'b0;
    sq_lat = 0;
    bus.irq_en = 1'b1;
    run(4'd0, 9, 0, 0);
    chk("tmo_ovf_cleared", ovf1, 0);
    chk("tmo_sqrt_starts", ss_n, 1);
    chk("tmo_ssel", ssel, 0);
    chk("tmo_we_n", we_n, 0);
    chk("tmo_done_n", done_n, 1);
    chk("tmo_done_cyc", done_cyc, 7);
    chk("tmo_ready_cyc", rdy_cyc, 7);
    chk("tmo_err", bus.err_timeout, 1);
    chk("tmo_irq", bus.irq, 1);
    bus.irq_clr = 1'b1;
    tick;
    bus.irq_clr = 1'b0;
    chk("irq_clr", bus.irq, 0);
    mul_lat = 3;
    run(4'd7, 10, 7, 8);
    chk("abort_we_n", we_n, 1);
    chk("abort_src", src[0], 2);
    chk("abort_done_n", done_n, 1);
    chk("abort_done_cyc", done_cyc, 8);
    chk("abort_sqrt_starts", ss_n, 0);
    chk("abort_ready_cyc", rdy_cyc, 8);
    chk("abort_errs", {bus.err_ovf, bus.err_timeout}, 0);
    chk("abort_irq_set_wins", bus.irq, 1);
    bus.irq_en = 1'b0;
    run(4'd2, 7, 4, 0);
    chk("abort_vs_done_we_n", we_n, 0);
    chk("abort_vs_done_cyc", done_cyc, 5);
    chk("abort_vs_done_n", done_n, 1);
    run(4'd4, 4, 0, 0);
    chk("op4_ssel", ssel, 1);
    chk("op4_busy_sqw", bus.busy, 1);
    rst = 1'b1;
    tick;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.cmd_ready, 1);
    chk("midrst_done", bus.done, 0);
    chk("midrst_irq", bus.irq, 0);
    rst = 1'b0;
    tick;
    chk("midrst_done_after", bus.done, 0);
    run(4'd9, 3, 0, 0);
    chk("op9_we_n", we_n, 1);
    chk("op9_we_cyc", wc[0], 1);
    chk("op9_src", src[0], 4);
    chk("op9_done_cyc", done_cyc, 1);
    chk("op9_ready_cyc", rdy_cyc, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
